moving_average_multi: RTL and testbench

Parametrised multi-channel moving-average filter and the next generation of our single-channel averager. It runs one independent running-sum filter per channel, with a runtime-selectable power-of-two window, signed or unsigned data, and optional rounding. Each channel's history lives in a per-channel ring buffer, so every sample costs a constant number of cycles regardless of window length. It sits between the sample front-end (strobe-qualified data) and downstream consumers that expect a strobe-qualified averaged value.

---
 rtl/moving_average_multi.sv | 151 +++++++++++++++
 tb/tb_moving_average_multi.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moving_average_multi.sv
// Multi-channel running-sum moving average with per-channel ring history and power-of-two window.
// Latency: 3 cycles from sample acceptance to the strobe_out pulse; one sample per 4 cycles.
// Backpressure: busy is high outside IDLE; strobe_in is ignored (not queued) while busy.
module moving_average_multi #(
  parameter int MAX_POWER   = 4,
  parameter int DATA_IN_LEN = 10,
  parameter int CHANNELS    = 2,
  parameter bit SIGNED      = 1'b0,
  parameter bit ROUND       = 1'b0,
  localparam int PW   = $clog2(MAX_POWER + 1),
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [PW-1:0]          win_power,
  input  logic [DATA_IN_LEN-1:0] data_in,
  input  logic [CH_W-1:0]        chan_in,
  input  logic                   strobe_in,
  output logic                   busy,
  output logic [DATA_IN_LEN-1:0] data_out,
  output logic [CH_W-1:0]        chan_out,
  output logic                   strobe_out,
  output logic                   valid_window
);

  localparam int DEPTH  = 1 << MAX_POWER;
  localparam int SUM_W  = DATA_IN_LEN + MAX_POWER;
  localparam int RW     = SUM_W + 1;
  localparam int FILL_W = MAX_POWER + 1;

  typedef enum logic [1:0] {IDLE, READ, UPDATE, OUT} state_t;

  state_t                 state;
  logic [DATA_IN_LEN-1:0] ring [CHANNELS][DEPTH];
  logic [MAX_POWER-1:0]   wp   [CHANNELS];
  logic [FILL_W-1:0]      fill [CHANNELS];
  logic [SUM_W-1:0]       sum  [CHANNELS];
  logic [PW-1:0]          ap;

  logic [DATA_IN_LEN-1:0] x_q;
  logic [DATA_IN_LEN-1:0] old_q;
  logic [DATA_IN_LEN-1:0] res_q;
  logic [CH_W-1:0]        ch_q;
  logic                   vld_q;

  logic [PW-1:0]          p_clamp;
  logic                   in_range;
  logic [FILL_W-1:0]      n_win;
  logic [MAX_POWER-1:0]   rd_idx;
  logic [SUM_W-1:0]       x_ext;
  logic [SUM_W-1:0]       old_ext;
  logic [SUM_W-1:0]       sum_new;
  logic [FILL_W-1:0]      fill_new;
  logic [RW-1:0]          rnd;
  logic [RW-1:0]          sum_rnd;
  logic [DATA_IN_LEN-1:0] res_next;

  assign busy = (state != IDLE);

  always_comb begin
    p_clamp  = (win_power > PW'(MAX_POWER)) ? PW'(MAX_POWER) : win_power;
    in_range = (32'(chan_in) < 32'(CHANNELS));
    n_win    = FILL_W'(1) << ap;
    // Oldest sample of the window; when N == depth this is the slot about to be overwritten.
    rd_idx   = wp[ch_q] - n_win[MAX_POWER-1:0];
    x_ext    = {{MAX_POWER{SIGNED & x_q[DATA_IN_LEN-1]}}, x_q};
    old_ext  = {{MAX_POWER{SIGNED & old_q[DATA_IN_LEN-1]}}, old_q};
    sum_new  = sum[ch_q] + x_ext - old_ext;
    fill_new = (fill[ch_q] == FILL_W'(DEPTH)) ? fill[ch_q] : fill[ch_q] + 1'b1;
    rnd      = '0;
    if (ROUND && (ap != '0)) rnd = RW'(1) << (ap - 1'b1);
    sum_rnd  = {SIGNED & sum_new[SUM_W-1], sum_new} + rnd;
    if (SIGNED) res_next = DATA_IN_LEN'($signed(sum_rnd) >>> ap);
    else        res_next = DATA_IN_LEN'(sum_rnd >> ap);
  end

  // History is never cleared: fill gates every read, so stale entries are harmless.
  always_ff @(posedge clk) begin
    if (!reset && !flush && (state == UPDATE)) ring[ch_q][wp[ch_q]] <= x_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ap           <= PW'(MAX_POWER);
      data_out     <= '0;
      chan_out     <= '0;
      strobe_out   <= 1'b0;
      valid_window <= 1'b0;
      x_q          <= '0;
      old_q        <= '0;
      res_q        <= '0;
      ch_q         <= '0;
      vld_q        <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        sum[c]  <= '0;
        fill[c] <= '0;
        wp[c]   <= '0;
      end
    end else if (flush) begin
      state      <= IDLE;
      strobe_out <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        sum[c]  <= '0;
        fill[c] <= '0;
        wp[c]   <= '0;
      end
    end else begin
      strobe_out <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe_in && in_range) begin
            x_q   <= data_in;
            ch_q  <= chan_in;
            state <= READ;
            // A new window restarts every channel; this sample is the first of it.
            if (p_clamp != ap) begin
              ap <= p_clamp;
              for (int c = 0; c < CHANNELS; c++) begin
                sum[c]  <= '0;
                fill[c] <= '0;
              end
            end
          end
        end
        READ: begin
          old_q <= (fill[ch_q] >= n_win) ? ring[ch_q][rd_idx] : '0;
          state <= UPDATE;
        end
        UPDATE: begin
          sum[ch_q]  <= sum_new;
          fill[ch_q] <= fill_new;
          wp[ch_q]   <= wp[ch_q] + 1'b1;
          res_q      <= res_next;
          vld_q      <= (fill_new >= n_win);
          state      <= OUT;
        end
        OUT: begin
          data_out     <= res_q;
          chan_out     <= ch_q;
          valid_window <= vld_q;
          strobe_out   <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_moving_average_multi.sv
// Bench for moving_average_multi: four instances covering every SIGNED/ROUND combination,
// driven by one shared stimulus stream and checked against a queue-based averaging model.
module tb_moving_average_multi;

  localparam int MP   = 4;
  localparam int D    = 10;
  localparam int CH   = 3;
  localparam int CH_W = 2;
  localparam int PW   = 3;

  logic            clk;
  logic            reset;
  logic            flush;
  logic [PW-1:0]   win_power;
  logic [D-1:0]    data_in;
  logic [CH_W-1:0] chan_in;
  logic            strobe_in;

  logic [3:0]      busy_w;
  logic [3:0]      strobe_w;
  logic [3:0]      vld_w;
  logic [D-1:0]    dat_w [4];
  logic [CH_W-1:0] chn_w [4];

  // Instance g: SIGNED = g%2, ROUND = g/2.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    moving_average_multi #(
      .MAX_POWER(MP), .DATA_IN_LEN(D), .CHANNELS(CH),
      .SIGNED(1'(g % 2)), .ROUND(1'(g / 2))
    ) dut (
      .clk(clk), .reset(reset), .flush(flush), .win_power(win_power),
      .data_in(data_in), .chan_in(chan_in), .strobe_in(strobe_in),
      .busy(busy_w[g]), .data_out(dat_w[g]), .chan_out(chn_w[g]),
      .strobe_out(strobe_w[g]), .valid_window(vld_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [D-1:0] hist [CH][$];
  int           ap_m;
  logic [D-1:0] last_dat [4];
  int           last_ch;
  int           last_vld;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < CH; c++) hist[c].delete();
  endfunction

  function automatic void model_window(int p);
    int pc;
    pc = (p > MP) ? MP : p;
    if (pc != ap_m) begin
      ap_m = pc;
      model_clear();
    end
  endfunction

  function automatic void model_push(int ch, logic [D-1:0] x);
    hist[ch].push_back(x);
    if (hist[ch].size() > (1 << MP)) void'(hist[ch].pop_front());
  endfunction

  // Sum of the last N samples (missing ones are zero), plus rounding bias, floor-divided by N.
  function automatic logic [D-1:0] model_avg(int g, int ch);
    longint s;
    longint v;
    int n;
    int sz;
    logic [63:0] r;
    s  = 0;
    n  = 1 << ap_m;
    sz = hist[ch].size();
    for (int i = 0; i < n && i < sz; i++) begin
      if (g % 2 == 1) v = longint'($signed(hist[ch][sz-1-i]));
      else            v = longint'(hist[ch][sz-1-i]);
      s += v;
    end
    if ((g / 2 == 1) && (ap_m > 0)) s += longint'(1) << (ap_m - 1);
    s = s >>> ap_m;
    r = s;
    return r[D-1:0];
  endfunction

  task automatic check_ctl(string tag, bit eb, bit es);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("%s.busy[%0d]", tag, g), 32'(busy_w[g]), 32'(eb));
      check($sformatf("%s.strobe[%0d]", tag, g), 32'(strobe_w[g]), 32'(es));
    end
  endtask

  task automatic check_res(string tag, int ch);
    int ev;
    ev = (hist[ch].size() >= (1 << ap_m)) ? 1 : 0;
    for (int g = 0; g < 4; g++) begin
      last_dat[g] = model_avg(g, ch);
      check($sformatf("%s.data[%0d]", tag, g), 32'(dat_w[g]), 32'(last_dat[g]));
      check($sformatf("%s.chan[%0d]", tag, g), 32'(chn_w[g]), 32'(ch));
      check($sformatf("%s.valid[%0d]", tag, g), 32'(vld_w[g]), 32'(ev));
    end
    last_ch  = ch;
    last_vld = ev;
  endtask

  task automatic check_held(string tag);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("%s.hold_data[%0d]", tag, g), 32'(dat_w[g]), 32'(last_dat[g]));
      check($sformatf("%s.hold_chan[%0d]", tag, g), 32'(chn_w[g]), 32'(last_ch));
      check($sformatf("%s.hold_valid[%0d]", tag, g), 32'(vld_w[g]), 32'(last_vld));
    end
  endtask

  task automatic drive(int ch, int x, int p);
    chan_in   = CH_W'(ch);
    data_in   = D'(x);
    win_power = PW'(p);
  endtask

  // Called at a negedge with all DUTs idle; returns at the negedge showing strobe_out.
  task automatic send(string tag, int ch, int x, int p);
    drive(ch, x, p);
    strobe_in = 1'b1;
    model_window(p);
    model_push(ch, D'(x));
    @(negedge clk);
    strobe_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_ctl($sformatf("%s.c%0d", tag, i + 1), 1'b1, 1'b0);
      @(negedge clk);
    end
    check_ctl($sformatf("%s.out", tag), 1'b0, 1'b1);
    check_res(tag, ch);
  endtask

  task automatic drop(string tag, bit with_flush, int ch, int x, int p);
    drive(ch, x, p);
    strobe_in = 1'b1;
    flush     = with_flush;
    @(negedge clk);
    strobe_in = 1'b0;
    flush     = 1'b0;
    if (with_flush) model_clear();
    check_held(tag);
    for (int i = 0; i < 4; i++) begin
      check_ctl($sformatf("%s.c%0d", tag, i + 1), 1'b0, 1'b0);
      @(negedge clk);
    end
  endtask

  // stage 1/2/3: flush or reset sampled while the sample is in READ/UPDATE/OUT.
  task automatic abort(string tag, bit use_reset, int stage, int ch, int x, int p);
    drive(ch, x, p);
    strobe_in = 1'b1;
    model_window(p);
    @(negedge clk);
    strobe_in = 1'b0;
    repeat (stage - 1) @(negedge clk);
    if (use_reset) reset = 1'b1;
    else           flush = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    model_clear();
    if (use_reset) begin
      ap_m = MP;
      for (int g = 0; g < 4; g++) last_dat[g] = '0;
      last_ch  = 0;
      last_vld = 0;
    end
    check_held(tag);
    for (int i = 0; i < 4; i++) begin
      check_ctl($sformatf("%s.c%0d", tag, i), 1'b0, 1'b0);
      @(negedge clk);
    end
  endtask

  // strobe_in held high with fresh inputs every cycle: acceptances must land 4 cycles apart.
  task automatic handshake(string tag);
    int hch;
    int hx;
    int hp;
    int acc_ch;
    acc_ch = 0;
    hch = $urandom_range(0, CH - 1);
    hx  = $urandom_range(0, (1 << D) - 1);
    hp  = $urandom_range(1, 3);
    drive(hch, hx, hp);
    strobe_in = 1'b1;
    for (int t = 0; t < 16; t++) begin
      if (t % 4 == 0) begin
        model_window(hp);
        model_push(hch, D'(hx));
        acc_ch = hch;
      end
      @(negedge clk);
      check_ctl($sformatf("%s.t%0d", tag, t), (t % 4) != 3, (t % 4) == 3);
      if (t % 4 == 3) check_res($sformatf("%s.t%0d", tag, t), acc_ch);
      hch = $urandom_range(0, CH - 1);
      hx  = $urandom_range(0, (1 << D) - 1);
      if ($urandom_range(0, 3) == 0) hp = $urandom_range(1, 3);
      drive(hch, hx, hp);
      if (t == 15) strobe_in = 1'b0;
    end
  endtask

  int seq_x [5] = '{4, 8, 12, 16, 20};
  int seq_e [5] = '{1, 3, 6, 10, 14};

  initial begin
    int cur_p;
    int op;
    int rx;
    int rch;
    reset     = 1'b1;
    flush     = 1'b0;
    strobe_in = 1'b0;
    drive(0, 0, 0);
    ap_m      = MP;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int g = 0; g < 4; g++) last_dat[g] = '0;
    last_ch  = 0;
    last_vld = 0;
    check_ctl("reset", 1'b0, 1'b0);
    check_held("reset");

    // Unsigned p=2 sequence with one ch1 sample interleaved.
    for (int i = 0; i < 5; i++) begin
      send("seq", 0, seq_x[i], 2);
      check("seq.lit", 32'(dat_w[0]), 32'(seq_e[i]));
      if (i == 1) begin
        send("ch1", 1, 100, 2);
        check("ch1.lit", 32'(dat_w[0]), 32'd25);
        check("ch1.lit_valid", 32'(vld_w[0]), 32'd0);
      end
    end
    check("seq.lit_valid", 32'(vld_w[0]), 32'd1);

    drop("fl1", 1'b1, 0, 0, 1);
    send("sgn", 2, -3, 1);
    check("sgn.lit0", 32'(dat_w[1]), 32'd1022);
    send("sgn", 2, -5, 1);
    check("sgn.lit1", 32'(dat_w[1]), 32'd1020);

    drop("fl2", 1'b1, 0, 0, 1);
    send("rnd", 0, 1, 1);
    check("rnd.lit0", 32'(dat_w[2]), 32'd1);
    send("rnd", 0, 2, 1);
    check("rnd.lit1", 32'(dat_w[2]), 32'd2);

    drop("fl3", 1'b1, 0, 0, 2);
    for (int i = 0; i < 4; i++) send("max", 0, 1023, 2);
    check("max.lit", 32'(dat_w[0]), 32'd1023);

    for (int i = 0; i < 4; i++) send("win", 1, 16, 2);
    check("win.lit0", 32'(dat_w[0]), 32'd16);
    send("win", 1, 10, 1);
    check("win.lit1", 32'(dat_w[0]), 32'd5);
    check("win.lit1_valid", 32'(vld_w[0]), 32'd0);
    send("win", 1, 10, 1);
    check("win.lit2", 32'(dat_w[0]), 32'd10);
    check("win.lit2_valid", 32'(vld_w[0]), 32'd1);

    handshake("hs");

    abort("ab_flush_rd", 1'b0, 1, 0, 50, 2);
    send("after_flush", 0, 8, 2);
    check("after_flush.lit", 32'(dat_w[0]), 32'd2);
    abort("ab_reset_up", 1'b1, 2, 1, 77, 2);
    drop("badch", 1'b0, CH, 33, 2);

    // Clamped window (7 -> MAX_POWER) long enough to saturate fill and wrap the ring.
    for (int i = 0; i < 20; i++) send("sat", 0, $urandom_range(0, (1 << D) - 1), 7);

    cur_p = 2;
    repeat (80) begin
      op  = $urandom_range(0, 19);
      rx  = $urandom_range(0, (1 << D) - 1);
      rch = $urandom_range(0, CH - 1);
      if ($urandom_range(0, 4) == 0) cur_p = $urandom_range(0, 7);
      if (op < 15)       send("rand", rch, rx, cur_p);
      else if (op == 15) drop("rand_badch", 1'b0, CH, rx, cur_p);
      else if (op == 16) drop("rand_flush_in", 1'b1, rch, rx, cur_p);
      else               abort("rand_abort", op == 17, $urandom_range(1, 3), rch, rx, cur_p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
